// File: rtl/mult_pkg.sv
// Shared widths and the tagged-result type for the shared multiplier arbiter.
package mult_pkg;

    localparam int MULT_W = 6;
    localparam int PROD_W = 12;
    localparam int NREQ   = 4;
    localparam int ID_W   = 2;

    // Result register contents: owning requester plus signed product
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [PROD_W-1:0] p;
    } res_t;

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/result bus of mult_share_arb. The master drives operands and
// accepts results; the slave is the arbiter itself.
interface mult_share_arb_if;
    import mult_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*MULT_W-1:0] req_a;
    logic [NREQ*MULT_W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [PROD_W-1:0]      res_p;
    logic                   res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_p
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_p
    );

endinterface

// File: rtl/array_mult_6bit.sv
// Signed 6x6 array multiplier: shifted partial products of the
// sign-extended multiplicand, the sign-bit row weighted negatively.
module array_mult_6bit
    import mult_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] pp  [MULT_W];
    logic [PROD_W-1:0] acc [MULT_W-1];

    assign a_ext = {{(PROD_W-MULT_W){a[MULT_W-1]}}, a};

    genvar gi;
    generate
        for (gi = 0; gi < MULT_W; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? (a_ext << gi) : '0;
        end

        assign acc[0] = pp[0];
        for (gi = 1; gi < MULT_W-1; gi++) begin : g_acc
            assign acc[gi] = acc[gi-1] + pp[gi];
        end
    endgenerate

    // b's sign bit carries weight -2^5, so its row is subtracted
    assign p = acc[MULT_W-2] - pp[MULT_W-1];

endmodule

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker; the search starts just after
// the last granted index and wraps around.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic       en,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id
);

    logic [1:0] idx;
    logic       found;

    // Scan last+1 .. last+4 (mod 4) and take the first requester found
    always_comb begin
        gnt    = '0;
        gnt_id = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && en && req[idx]) begin
                found    = 1'b1;
                gnt      = 4'b0001 << idx;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one array_mult_6bit between four requesters with round-robin
// grants and a tagged output register.
// Define MULT_PIPE_EN to insert an operand stage before the multiplier
// (latency 2 instead of 1, throughput unchanged).
module mult_share_arb
    import mult_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mult_share_arb_if.slave bus
);

    logic [MULT_W-1:0] a_arr [NREQ];
    logic [MULT_W-1:0] b_arr [NREQ];

    logic [ID_W-1:0]   last_q, last_d;
    logic              res_valid_q, res_valid_d;
    res_t              res_q, res_d;

    logic              free_out;
    logic              arb_en;
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              grant_any;

    logic [MULT_W-1:0] mult_a, mult_b;
    logic [PROD_W-1:0] mult_p;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_split
            assign a_arr[gi] = bus.req_a[gi*MULT_W +: MULT_W];
            assign b_arr[gi] = bus.req_b[gi*MULT_W +: MULT_W];
        end
    endgenerate

    // Output slot can take a new product if empty or being drained now
    assign free_out  = ~res_valid_q | bus.res_ready;
    assign grant_any = |gnt;

    rr_arb4 u_arb (
        .req    (bus.req_valid),
        .last   (last_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    array_mult_6bit u_mult (
        .a (mult_a),
        .b (mult_b),
        .p (mult_p)
    );

    // Pointer follows the most recent grant
    always_comb begin
        last_d = last_q;
        if (grant_any) begin
            last_d = gnt_id;
        end
    end

`ifdef MULT_PIPE_EN
    logic              stg_valid_q, stg_valid_d;
    logic [ID_W-1:0]   stg_id_q, stg_id_d;
    logic [MULT_W-1:0] stg_a_q, stg_a_d;
    logic [MULT_W-1:0] stg_b_q, stg_b_d;
    logic              stg_adv;

    // Stage moves when empty or when its content drops into the output slot
    assign stg_adv = ~stg_valid_q | free_out;
    assign arb_en  = stg_adv & ~rst;
    assign mult_a  = stg_a_q;
    assign mult_b  = stg_b_q;

    // Operand stage: capture the granted pair whenever the stage advances
    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_id_d    = stg_id_q;
        stg_a_d     = stg_a_q;
        stg_b_d     = stg_b_q;
        if (stg_adv) begin
            stg_valid_d = grant_any;
            if (grant_any) begin
                stg_id_d = gnt_id;
                stg_a_d  = a_arr[gnt_id];
                stg_b_d  = b_arr[gnt_id];
            end
        end
    end

    // Output slot: takes the staged product when free, otherwise holds
    always_comb begin
        res_valid_d = res_valid_q;
        res_d       = res_q;
        if (free_out) begin
            res_valid_d = stg_valid_q;
            if (stg_valid_q) begin
                res_d.id = stg_id_q;
                res_d.p  = mult_p;
            end
        end
    end

    // Operand stage flops
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_id_q    <= '0;
            stg_a_q     <= '0;
            stg_b_q     <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_id_q    <= stg_id_d;
            stg_a_q     <= stg_a_d;
            stg_b_q     <= stg_b_d;
        end
    end
`else
    assign arb_en = free_out & ~rst;
    assign mult_a = a_arr[gnt_id];
    assign mult_b = b_arr[gnt_id];

    // Output slot: loads the granted product directly, clears on bare drain
    always_comb begin
        res_valid_d = res_valid_q;
        res_d       = res_q;
        if (free_out) begin
            res_valid_d = grant_any;
            if (grant_any) begin
                res_d.id = gnt_id;
                res_d.p  = mult_p;
            end
        end
    end
`endif

    // Pointer and output register; last=3 gives requester 0 first priority
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 2'd3;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_q.id;
    assign bus.res_p     = res_q.p;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed cases followed by
// random traffic, checked every cycle against a transaction-level model.
module tb_mult_share_arb;
    import mult_pkg::*;

`ifdef MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_share_arb_if bus_if ();

    mult_share_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // requester-side stimulus state
    bit         pend [4];
    logic [5:0] pa   [4];
    logic [5:0] pb   [4];
    bit         rr_drv;
    bit         rst_drv;

    // reference model: output slot and optional operand stage as plain values
    bit m_known;
    int m_last;
    bit m_out_v;
    int m_out_id;
    int m_out_p;
    bit m_stg_v;
    int m_stg_id;
    int m_stg_p;

    // values sampled from the DUT in the most recent cycle
    logic [3:0]  s_ready;
    logic        s_valid;
    logic [1:0]  s_id;
    logic [11:0] s_p;
    int          dut_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int prod12(input logic [5:0] a, input logic [5:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return (ia * ib) & 'hFFF;
    endfunction

    // One clock cycle: drive, check against the model, advance the model
    task automatic cycle();
        bit free_out;
        bit en;
        int gid;
        int exp_ready;
        for (int i = 0; i < 4; i++) begin
            bus_if.req_valid[i]      = pend[i];
            bus_if.req_a[i*6 +: 6]   = pa[i];
            bus_if.req_b[i*6 +: 6]   = pb[i];
        end
        bus_if.res_ready = rr_drv;
        rst = rst_drv;
        #2;
        free_out = !m_out_v || rr_drv;
`ifdef MULT_PIPE_EN
        en = (!m_stg_v || free_out) && !rst_drv;
`else
        en = free_out && !rst_drv;
`endif
        gid = -1;
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (gid < 0 && pend[i]) gid = i;
        end
        if (!en) gid = -1;
        exp_ready = (gid >= 0) ? (1 << gid) : 0;

        s_ready = bus_if.req_ready;
        s_valid = bus_if.res_valid;
        s_id    = bus_if.res_id;
        s_p     = bus_if.res_p;
        check("req_ready", 32'(s_ready), 32'(exp_ready));
        if (m_known) begin
            check("res_valid", 32'(s_valid), 32'(m_out_v));
            check("res_id", 32'(s_id), 32'(m_out_id));
            check("res_p", 32'(s_p), 32'(m_out_p));
        end
        if (s_valid === 1'b1 && rr_drv && !rst_drv) dut_q.push_back(int'(s_id));

        if (rst_drv) begin
            m_known  = 1'b1;
            m_last   = 3;
            m_out_v  = 1'b0;
            m_out_id = 0;
            m_out_p  = 0;
            m_stg_v  = 1'b0;
        end else begin
            if (m_out_v && rr_drv)
                $display("xfer id=%0d p=%03h", m_out_id, m_out_p);
`ifdef MULT_PIPE_EN
            if (free_out) begin
                if (m_stg_v) begin
                    m_out_id = m_stg_id;
                    m_out_p  = m_stg_p;
                end
                m_out_v = m_stg_v;
            end
            if (!m_stg_v || free_out) begin
                m_stg_v = (gid >= 0);
                if (gid >= 0) begin
                    m_stg_id = gid;
                    m_stg_p  = prod12(pa[gid], pb[gid]);
                end
            end
`else
            if (free_out) begin
                m_out_v = (gid >= 0);
                if (gid >= 0) begin
                    m_out_id = gid;
                    m_out_p  = prod12(pa[gid], pb[gid]);
                end
            end
`endif
            if (gid >= 0) begin
                m_last    = gid;
                pend[gid] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        cycle();
        rst_drv = 1'b0;
    endtask

    task automatic run_single(input string tag, input int id, input logic [5:0] a,
                              input logic [5:0] b, input logic [11:0] exp_p);
        pend[id] = 1'b1;
        pa[id]   = a;
        pb[id]   = b;
        rr_drv   = 1'b1;
        cycle();
        check({tag, "_rdy"}, 32'(s_ready), 32'(1 << id));
        for (int c = 0; c < LAT; c++) cycle();
        check({tag, "_v"}, 32'(s_valid), 32'd1);
        check({tag, "_id"}, 32'(s_id), 32'(id));
        check({tag, "_p"}, 32'(s_p), 32'(exp_p));
    endtask

    initial begin
        int base;
        bit v_seen [4];
        int id_seen [4];
        m_known = 1'b0;
        m_last  = 3;
        m_out_v = 1'b0;
        m_stg_v = 1'b0;
        m_out_id = 0;
        m_out_p  = 0;
        m_stg_id = 0;
        m_stg_p  = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pb[i]   = '0;
        end
        rr_drv  = 1'b1;
        rst_drv = 1'b1;
        rst     = 1'b1;
        bus_if.req_valid = '0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        bus_if.res_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        do_reset();
        cycle();
        check("reset_valid", 32'(s_valid), 32'd0);
        check("reset_p", 32'(s_p), 32'd0);

        // single request and sign cases
        run_single("single", 0, 6'd7, 6'd9, 12'h03F);
        run_single("s_5xm3", 2, 6'd5, 6'h3D, 12'hFF1);
        run_single("s_m32xm32", 1, 6'h20, 6'h20, 12'h400);
        run_single("s_m32x31", 3, 6'h20, 6'd31, 12'hC20);
        run_single("s_0xm1", 0, 6'd0, 6'h3F, 12'h000);

        // all four continuously valid from reset: grants rotate 0,1,2,3,0
        do_reset();
        base = dut_q.size();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b1;
            pa[i]   = 6'(i + 1);
            pb[i]   = 6'(i + 3);
        end
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rot_gnt", 32'(s_ready), 32'(1 << (k % 4)));
            for (int i = 0; i < 4; i++) pend[i] = 1'b1;
        end
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        for (int c = 0; c < LAT + 1; c++) cycle();
        check("rot_cnt", 32'(dut_q.size() - base), 32'd5);
        if (dut_q.size() - base == 5) begin
            for (int k = 0; k < 5; k++)
                check("rot_order", 32'(dut_q[base + k]), 32'(k % 4));
        end

        // backpressure: three stalled cycles with work pending
        base = dut_q.size();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b1;
            pa[i]   = 6'($urandom_range(0, 63));
            pb[i]   = 6'($urandom_range(0, 63));
        end
        rr_drv = 1'b1;
        for (int c = 0; c < LAT + 1; c++) cycle();
        rr_drv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("bp_ready", 32'(s_ready), 32'd0);
            check("bp_valid", 32'(s_valid), 32'd1);
        end
        rr_drv = 1'b1;
        for (int c = 0; c < 8; c++) cycle();
        check("bp_count", 32'(dut_q.size() - base), 32'd4);

        // reset while a product is pending
        pend[0] = 1'b1;
        pa[0]   = 6'd3;
        pb[0]   = 6'd4;
        rr_drv  = 1'b0;
        cycle();
        cycle();
        do_reset();
        pend[1] = 1'b1;
        pa[1]   = 6'd2;
        pb[1]   = 6'd2;
        pend[2] = 1'b1;
        pa[2]   = 6'd5;
        pb[2]   = 6'd5;
        rr_drv  = 1'b1;
        cycle();
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_first", 32'(s_ready), 32'b0010);
        for (int c = 0; c < 4; c++) cycle();

        // back-to-back: drain of req0's product and load of req3's together
        pend[0] = 1'b1;
        pa[0]   = 6'd11;
        pb[0]   = 6'd2;
        rr_drv  = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            if (c == 1) begin
                pend[3] = 1'b1;
                pa[3]   = 6'h3E;
                pb[3]   = 6'd7;
            end
            cycle();
            if (c >= LAT) begin
                v_seen[c - LAT]  = s_valid;
                id_seen[c - LAT] = int'(s_id);
            end
        end
        check("b2b_v0", 32'(v_seen[0]), 32'd1);
        check("b2b_id0", 32'(id_seen[0]), 32'd0);
        check("b2b_v1", 32'(v_seen[1]), 32'd1);
        check("b2b_id1", 32'(id_seen[1]), 32'd3);
        check("b2b_p1", 32'(s_p), 32'hFF2);

        // random traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = 6'($urandom_range(0, 63));
                    pb[i]   = 6'($urandom_range(0, 63));
                end
            end
            rr_drv = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rr_drv = 1'b1;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        check("drain_valid", 32'(s_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one `array_mult_6bit` signed 6x6 multiplier between four requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one pair per cycle, drives it through the multiplier and holds the tagged 12-bit product in an output register until a single consumer accepts it. It sits between the operand sources and the downstream result logic, so the design needs only one multiplier.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4, so the ID width is 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: requester i has an operand pair on its bus.
- `req_a` input NREQ*6: operand a of requester i in bits [6i+5:6i]; two's complement.
- `req_b` input NREQ*6: operand b of requester i in bits [6i+5:6i]; two's complement.
- `req_ready` output NREQ: one-hot or zero; bit i high means requester i's pair is accepted this cycle.
- `res_valid` output 1: the output register holds a product.
- `res_id` output 2: index of the requester that owns the product.
- `res_p` output 12: signed product a*b.
- `res_ready` input 1: the consumer accepts the product this cycle.

## Operation
- **Handshakes:** a transfer occurs when `req_valid[i] & req_ready[i]` on the request side, and when `res_valid & res_ready` on the result side.
- **Slot free condition:** `free = ~res_valid | res_ready`. With MULT_PIPE_EN, this condition is also qualified by the pipeline stage (see Configuration).
- **Grant rule:**
  - `req_ready[i]` is high only for the highest-priority valid requester, and only when free is high.
  - `req_ready` is combinational from `req_valid`, `res_ready` and the state.
  - At most one bit is set.
- **Round-robin pointer `last`:**
  - Priority order is last+1, last+2, ..., last (mod 4).
  - `last` is updated to the granted index on each grant. It is unchanged when there is no grant.
- **Request stability:** a requester must hold `req_valid`, `req_a` and `req_b` stable until accepted. The block never drops a pending request.
- **Result register:**
  - On a grant, the register loads {id, a*b} and sets `res_valid`.
  - On a drain with no new load, it clears `res_valid`.
  - On a simultaneous drain and load, the register takes the new product and `res_valid` stays 1.
- **Arithmetic:**
  - Full signed 12-bit product; no overflow is possible.
  - Range is -992 to +1024.
  - The product comes from the `array_mult_6bit` instance.
- **Backpressure:** while `res_valid & ~res_ready`, `res_id` and `res_p` hold and all `req_ready` bits are 0.
- **Reset:**
  - Reset clears `res_valid` and the pipeline valid, and sets `last` = 3 so that requester 0 has first priority.
  - `req_ready` is 0 during reset.
  - In-flight operations are discarded, with no partial output.
  - `res_id` and `res_p` reset to 0.

## Timing
- **Default latency:** 1 cycle from the grant edge to `res_valid`.
- **Throughput:** 1 product per cycle when `res_ready` is held high.
- **Fairness:** with all four requesters continuously valid, grants rotate 0,1,2,3,0,... Each requester waits at most 3 grants between its own.
- **Combinational paths:**
  - `res_ready` to `req_ready` (one level of gating).
  - Multiplier input to the result register D input.
  - There is no path from `req_valid` to `res_valid`.

## Configuration
- `MULT_PIPE_EN` defined:
  - An operand register stage (`stg_valid`, `stg_id`, `stg_a`, `stg_b`) is inserted before the multiplier. Latency becomes 2 cycles.
  - The stage advances when `~stg_valid | free_out`.
  - A grant is allowed when the stage can advance.
  - Full throughput is kept; a stall holds both stages.
  - Reset clears `stg_valid`.
- `MULT_PIPE_EN` undefined: single-stage, latency 1, as described above.

## Structure
- **Shared package `mult_pkg`:** `MULT_W` = 6, `PROD_W` = 12, `NREQ` = 4, `ID_W` = 2, and a `res_t` struct type {id, p}.
- **Sub-module `rr_arb4`:** combinational 4-way round-robin picker. Inputs are req[3:0], last[1:0] and en. Outputs are gnt[3:0] (one-hot) and gnt_id[1:0].
- **Top level:** holds the `last` register, the pipeline stage and the result register, plus the `array_mult_6bit` instance.

## Test plan
- **Single request:**
  - Stimulus: req0 with a=7, b=9.
  - Response: `req_ready`=0001 that cycle; one cycle later (two with MULT_PIPE_EN) `res_valid`=1, `res_id`=0, `res_p`=0x03F.
- **Sign cases:**
  - 5*-3 gives 0xFF1.
  - -32*-32 gives 0x400.
  - -32*31 gives 0xC20.
  - 0*-1 gives 0x000.
- **All four valid, `res_ready`=1:** grants go 0,1,2,3,0; ids appear in the same order; one result per cycle.
- **Backpressure:** hold `res_ready`=0 for 3 cycles with results pending. `res_p` and `res_id` stay stable, `req_ready`=0000 and no product is lost. After release, the stream resumes in order.
- **Reset mid-stream:**
  - Stimulus: assert `rst` for 1 cycle while a product is pending.
  - Response: next cycle `res_valid`=0 and `last`=3; with req1 and req2 valid, the first grant is 1.
- **Simultaneous drain and load:**
  - Stimulus: `res_valid`=1, `res_ready`=1 and req3 valid in the same cycle.
  - Response: the register takes req3's product the next cycle with no bubble.
